// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per accepted request as a start/8-data/[parity]/stop frame.
// Latency: tx_out falls and busy rises on the accepting edge; done pulses on the edge ending the stop bit.
// Backpressure: tx_start is ignored while busy is high; no queueing, so the requester must wait for idle.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] Tx,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  // Baud counter is at least one bit wide even for the smallest legal bit period.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;

  logic          bit_end_d;
  logic          par_d;
  logic          par_bit_d;

  // A bit period ends on the edge where the counter has reached its last value.
  assign bit_end_d = (cnt_q == CNT_LAST);
  // Accumulator including the data bit currently on the line; used when it completes.
  assign par_d     = par_q ^ shift_q[0];
  assign par_bit_d = (PARITY == 2) ? ~par_d : par_d;

  // Frame sequencer; every output is a register updated here so nothing is combinational from inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          if (tx_start) begin
            shift_q <= Tx;
            par_q   <= 1'b0;
            idx_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end_d) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end_d) begin
            cnt_q   <= '0;
            par_q   <= par_d;
            shift_q <= {1'b0, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              if (PARITY != 0) begin
                tx_q    <= par_bit_d;
                state_q <= PAR;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              // Next LSB is shift_q[1] because the shift lands on this same edge.
              tx_q  <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PAR: begin
          if (bit_end_d) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end_d) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
